// File: rtl/mipi_csi_packet_parser.sv
// CSI-2 packet parser: decodes sync short packets and long-packet headers,
// forwards RAW10 payload words of one virtual channel with byte enables.
module mipi_csi_packet_parser #(
  parameter logic [5:0] DATA_TYPE = 6'h2B,
  parameter logic [1:0] VC        = 2'd0
) (
  input  logic        clk_i,
  input  logic        reset,
  input  logic [31:0] data_i,
  input  logic        data_valid_i,
  output logic [31:0] data_o,
  output logic        data_valid_o,
  output logic [3:0]  byte_en_o,
  output logic        frame_start_o,
  output logic        frame_end_o,
  output logic        line_start_o,
  output logic        line_end_o,
  output logic        frame_active_o,
  output logic [15:0] line_count_o,
  output logic [15:0] word_count_o,
  output logic        pkt_err_o
);

  typedef enum logic [1:0] {
    S_HDR,
    S_PAYLOAD,
    S_DRAIN
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] rem_q, rem_d;
  logic [31:0] data_q, data_d;
  logic        valid_q, valid_d;
  logic [3:0]  be_q, be_d;
  logic        fs_q, fs_d;
  logic        fe_q, fe_d;
  logic        ls_q, ls_d;
  logic        le_q, le_d;
  logic        err_q, err_d;
  logic        active_q, active_d;
  logic [15:0] lc_q, lc_d;
  logic [15:0] wc_q, wc_d;

  logic [1:0]  hdr_vc;
  logic [5:0]  hdr_dt;
  logic [15:0] hdr_wc;
  logic        vc_ok;
  logic        is_sync;
  logic        is_line;
  logic [31:0] byte_mask;

  assign hdr_vc  = data_i[7:6];
  assign hdr_dt  = data_i[5:0];
  assign hdr_wc  = data_i[23:8];
  assign vc_ok   = (hdr_vc == VC);
  assign is_sync = vc_ok && (hdr_dt < 6'h04);
  assign is_line = vc_ok && (hdr_dt >= 6'h10) &&
                   (hdr_dt == DATA_TYPE) && (hdr_wc != 16'd0);

  assign byte_mask = {{8{be_d[3]}}, {8{be_d[2]}},
                      {8{be_d[1]}}, {8{be_d[0]}}};

  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    valid_d  = 1'b0;
    be_d     = 4'b0000;
    fs_d     = 1'b0;
    fe_d     = 1'b0;
    ls_d     = 1'b0;
    le_d     = 1'b0;
    err_d    = 1'b0;
    active_d = active_q;
    lc_d     = lc_q;
    wc_d     = wc_q;

    unique case (state_q)
      S_HDR: begin
        if (data_valid_i) begin
          state_d = S_DRAIN;
          unique case (1'b1)
            is_sync && hdr_dt == 6'h00: begin
              fs_d     = 1'b1;
              err_d    = active_q;
              active_d = 1'b1;
              lc_d     = 16'd0;
            end
            is_sync && hdr_dt == 6'h01: begin
              fe_d     = 1'b1;
              active_d = 1'b0;
            end
            is_sync && hdr_dt == 6'h02: ls_d = 1'b1;
            is_sync && hdr_dt == 6'h03: le_d = 1'b1;
            is_line: begin
              wc_d    = hdr_wc;
              rem_d   = hdr_wc;
              lc_d    = (lc_q == 16'hFFFF) ? lc_q : lc_q + 16'd1;
              state_d = S_PAYLOAD;
            end
            default: ;
          endcase
        end
      end
      S_PAYLOAD: begin
        if (data_valid_i) begin
          valid_d = 1'b1;
          if (rem_q > 16'd4) begin
            be_d  = 4'b1111;
            rem_d = rem_q - 16'd4;
          end else begin
            // last payload word: trailing CRC bytes get masked off
            unique case (rem_q[2:0])
              3'd4:    be_d = 4'b1111;
              3'd3:    be_d = 4'b0111;
              3'd2:    be_d = 4'b0011;
              default: be_d = 4'b0001;
            endcase
            rem_d   = 16'd0;
            state_d = S_DRAIN;
          end
        end else begin
          err_d   = 1'b1;
          rem_d   = 16'd0;
          state_d = S_HDR;
        end
      end
      S_DRAIN: begin
        if (!data_valid_i) state_d = S_HDR;
      end
      default: state_d = S_HDR;
    endcase

    data_d = valid_d ? (data_i & byte_mask) : 32'd0;
  end

  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      state_q  <= S_HDR;
      rem_q    <= 16'd0;
      data_q   <= 32'd0;
      valid_q  <= 1'b0;
      be_q     <= 4'b0000;
      fs_q     <= 1'b0;
      fe_q     <= 1'b0;
      ls_q     <= 1'b0;
      le_q     <= 1'b0;
      err_q    <= 1'b0;
      active_q <= 1'b0;
      lc_q     <= 16'd0;
      wc_q     <= 16'd0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      be_q     <= be_d;
      fs_q     <= fs_d;
      fe_q     <= fe_d;
      ls_q     <= ls_d;
      le_q     <= le_d;
      err_q    <= err_d;
      active_q <= active_d;
      lc_q     <= lc_d;
      wc_q     <= wc_d;
    end
  end

  assign data_o         = data_q;
  assign data_valid_o   = valid_q;
  assign byte_en_o      = be_q;
  assign frame_start_o  = fs_q;
  assign frame_end_o    = fe_q;
  assign line_start_o   = ls_q;
  assign line_end_o     = le_q;
  assign pkt_err_o      = err_q;
  assign frame_active_o = active_q;
  assign line_count_o   = lc_q;
  assign word_count_o   = wc_q;

endmodule
